// File: rtl/calc_pkg.sv
// Shared constants for the calculator controller.
//   DIGIT_W      : bits per BCD digit
//   S_*          : controller state encoding
//   OP_*         : operator codes as delivered by the keypad and shown on op_pend
//   is_valid_op  : true for the operator codes the controller acts on
package calc_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_OP   = 3'd1;
    localparam logic [2:0] S_B    = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_RES  = 3'd4;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_ADD  = 2'd1;
    localparam logic [1:0] OP_SUB  = 2'd2;

    function automatic logic is_valid_op(input logic [1:0] v);
        return (v == OP_ADD) || (v == OP_SUB);
    endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Keypad-to-calculator and calculator-to-display signal bundle.
//   master : keypad side, drives key flags/values, observes display outputs
//   slave  : calculator controller
// Signals: btn_press, is_number, is_op, is_eq, num_val[3:0], op_val[1:0]
//          disp_bcd[4*NDIGITS-1:0], disp_neg, disp_ovf, op_pend[1:0], busy
interface calc_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   btn_press;
    logic                   is_number;
    logic                   is_op;
    logic                   is_eq;
    logic [3:0]             num_val;
    logic [1:0]             op_val;
    logic [4*NDIGITS-1:0]   disp_bcd;
    logic                   disp_neg;
    logic                   disp_ovf;
    logic [1:0]             op_pend;
    logic                   busy;

    modport master (
        output btn_press, is_number, is_op, is_eq, num_val, op_val,
        input  disp_bcd, disp_neg, disp_ovf, op_pend, busy
    );

    modport slave (
        input  btn_press, is_number, is_op, is_eq, num_val, op_val,
        output disp_bcd, disp_neg, disp_ovf, op_pend, busy
    );
endinterface

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD adder/subtractor.
//   a, b  : BCD digits
//   cin   : decimal carry-in (add) or borrow-in (subtract)
//   sub   : 1 = a - b - cin, 0 = a + b + cin
//   digit : BCD result digit
//   cout  : decimal carry-out (add) or borrow-out (subtract)
module bcd_digit_addsub
    import calc_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    input  logic               sub,
    output logic [DIGIT_W-1:0] digit,
    output logic               cout
);
    logic [DIGIT_W:0] sum;
    logic [DIGIT_W:0] diff;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
        diff  = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, cin};
        digit = sum[DIGIT_W-1:0];
        cout  = 1'b0;
        if (sub) begin
            // A negative difference wraps in 4 bits; adding 10 mod 16 gives the BCD digit.
            cout  = diff[DIGIT_W];
            digit = diff[DIGIT_W] ? (diff[DIGIT_W-1:0] + 4'd10) : diff[DIGIT_W-1:0];
        end else if (sum > 5'd9) begin
            cout  = 1'b1;
            digit = sum[DIGIT_W-1:0] + 4'd6;
        end
    end
endmodule

// File: rtl/calc_ctrl.sv
// Calculator entry and arithmetic controller.
// Assembles two BCD operands from keypad events and computes BCD add or
// subtract one digit per clock (LS digit first) after '='.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : calc_ctrl_if.slave -- keypad flags/values in, display value,
//           sign/overflow flags, pending operator and busy out
module calc_ctrl
    import calc_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    calc_ctrl_if.slave  bus
);
    localparam int W  = DIGIT_W * NDIGITS;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = $clog2(NDIGITS + 1);

    logic [2:0]         state_reg;
    logic               btn_press_d_reg;
    logic [W-1:0]       opa_reg;
    logic [W-1:0]       opb_reg;
    logic [W-1:0]       res_reg;
    logic [CW-1:0]      cnt_reg;
    logic [1:0]         op_reg;
    logic               neg_reg;
    logic               ovf_reg;
    logic [IW-1:0]      idx_reg;
    logic               carry_reg;

    logic               kev;
    logic               dig_ev;
    logic               op_ev;
    logic               eq_ev;
    logic               cnt_room;

    assign kev      = bus.btn_press & ~btn_press_d_reg;
    assign dig_ev   = kev & bus.is_number & (bus.num_val <= 4'd9);
    assign op_ev    = kev & bus.is_op & is_valid_op(bus.op_val);
    assign eq_ev    = kev & bus.is_eq;
    assign cnt_room = (cnt_reg < CW'(NDIGITS));

    // For a negative subtraction neg_reg is decided on entry to S_CALC and the
    // operands are swapped so the digit path always computes larger - smaller.
    logic [W-1:0]         a_word;
    logic [W-1:0]         b_word;
    logic [DIGIT_W-1:0]   a_dig [NDIGITS];
    logic [DIGIT_W-1:0]   b_dig [NDIGITS];
    logic [DIGIT_W-1:0]   sum_dig;
    logic                 sum_cout;

    assign a_word = neg_reg ? opb_reg : opa_reg;
    assign b_word = neg_reg ? opa_reg : opb_reg;

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_dig
            assign a_dig[gi] = a_word[gi*DIGIT_W +: DIGIT_W];
            assign b_dig[gi] = b_word[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    bcd_digit_addsub u_digit (
        .a     (a_dig[idx_reg]),
        .b     (b_dig[idx_reg]),
        .cin   (carry_reg),
        .sub   (op_reg == OP_SUB),
        .digit (sum_dig),
        .cout  (sum_cout)
    );

    // The edge detector keeps sampling through reset so a key held across
    // reset is seen as already pressed and produces no event afterwards.
    always_ff @(posedge clk) begin
        btn_press_d_reg <= bus.btn_press;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_A;
            opa_reg   <= '0;
            opb_reg   <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            op_reg    <= OP_NONE;
            neg_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_A: begin
                    if (dig_ev) begin
                        if (cnt_room) begin
                            opa_reg <= {opa_reg[W-DIGIT_W-1:0], bus.num_val};
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (op_ev) begin
                        op_reg    <= bus.op_val;
                        state_reg <= S_OP;
                    end
                end
                S_OP: begin
                    if (dig_ev) begin
                        opb_reg   <= {{(W-DIGIT_W){1'b0}}, bus.num_val};
                        cnt_reg   <= CW'(1);
                        state_reg <= S_B;
                    end else if (op_ev) begin
                        op_reg <= bus.op_val;
                    end
                end
                S_B: begin
                    if (dig_ev) begin
                        if (cnt_room) begin
                            opb_reg <= {opb_reg[W-DIGIT_W-1:0], bus.num_val};
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else if (eq_ev) begin
                        // Packed BCD orders the same as binary, so a plain compare picks the sign.
                        neg_reg   <= (op_reg == OP_SUB) && (opa_reg < opb_reg);
                        ovf_reg   <= 1'b0;
                        idx_reg   <= '0;
                        carry_reg <= 1'b0;
                        state_reg <= S_CALC;
                    end
                end
                S_CALC: begin
                    res_reg[idx_reg*DIGIT_W +: DIGIT_W] <= sum_dig;
                    carry_reg <= sum_cout;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == IW'(NDIGITS - 1)) begin
                        ovf_reg   <= (op_reg == OP_ADD) & sum_cout;
                        state_reg <= S_RES;
                    end
                end
                S_RES: begin
                    if (dig_ev) begin
                        opa_reg   <= {{(W-DIGIT_W){1'b0}}, bus.num_val};
                        cnt_reg   <= CW'(1);
                        neg_reg   <= 1'b0;
                        ovf_reg   <= 1'b0;
                        op_reg    <= OP_NONE;
                        state_reg <= S_A;
                    end else if (op_ev) begin
                        // Chaining keeps the magnitude only; the sign is dropped.
                        opa_reg   <= res_reg;
                        op_reg    <= bus.op_val;
                        neg_reg   <= 1'b0;
                        ovf_reg   <= 1'b0;
                        state_reg <= S_OP;
                    end
                end
                default: state_reg <= S_A;
            endcase
        end
    end

    always_comb begin
        bus.disp_bcd = opa_reg;
        case (state_reg)
            S_B, S_CALC: bus.disp_bcd = opb_reg;
            S_RES:       bus.disp_bcd = res_reg;
            default:     bus.disp_bcd = opa_reg;
        endcase
    end

    assign bus.disp_neg = (state_reg == S_RES) & neg_reg;
    assign bus.disp_ovf = (state_reg == S_RES) & ovf_reg;
    assign bus.op_pend  = op_reg;
    assign bus.busy     = (state_reg == S_CALC);

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

    localparam int K_D = 0;
    localparam int K_O = 1;
    localparam int K_E = 2;

    typedef struct {
        int         kind;
        logic [3:0] val;
        logic [15:0] e_disp;
        logic       e_neg;
        logic       e_ovf;
        logic [1:0] e_op;
        int         e_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    calc_ctrl_if #(.NDIGITS(4)) bus ();

    calc_ctrl #(.NDIGITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic vec_t mk(int kind, logic [3:0] val, logic [15:0] d,
                                logic n, logic o, logic [1:0] op, int b);
        vec_t v;
        v.kind = kind; v.val = val; v.e_disp = d; v.e_neg = n;
        v.e_ovf = o; v.e_op = op; v.e_busy = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_key(input int kind, input logic [3:0] val);
        bus.is_number = (kind == K_D);
        bus.is_op     = (kind == K_O);
        bus.is_eq     = (kind == K_E);
        bus.num_val   = (kind == K_D) ? val : 4'd0;
        bus.op_val    = (kind == K_O) ? val[1:0] : 2'd0;
        bus.btn_press = 1'b1;
    endtask

    task automatic release_key();
        bus.btn_press = 1'b0;
        bus.is_number = 1'b0;
        bus.is_op     = 1'b0;
        bus.is_eq     = 1'b0;
        bus.num_val   = 4'd0;
        bus.op_val    = 2'd0;
    endtask

    // Press for 'hold' cycles; returns just after the release edge.
    task automatic press(input int kind, input logic [3:0] val, input int hold);
        @(posedge clk); #1;
        drive_key(kind, val);
        repeat (hold) @(posedge clk);
        #1;
        release_key();
    endtask

    task automatic apply(input vec_t v, input string tag);
        int n;
        press(v.kind, v.val, 1);
        n = 0;
        if (v.kind == K_E) begin
            while (bus.busy && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check({tag, " busy_cycles"}, n, v.e_busy);
        end
        @(posedge clk); #1;
        $display("%s kind=%0d val=%0d disp=%04h neg=%0b ovf=%0b op=%0d busy=%0d",
                 tag, v.kind, v.val, bus.disp_bcd, bus.disp_neg, bus.disp_ovf, bus.op_pend, n);
        check({tag, " disp_bcd"}, bus.disp_bcd, v.e_disp);
        check({tag, " disp_neg"}, bus.disp_neg, v.e_neg);
        check({tag, " disp_ovf"}, bus.disp_ovf, v.e_ovf);
        check({tag, " op_pend"},  bus.op_pend,  v.e_op);
        check({tag, " busy"},     bus.busy,     1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        release_key();
        repeat (2) @(posedge clk);
        #1;
        check("reset disp_bcd", bus.disp_bcd, 16'h0000);
        check("reset disp_neg", bus.disp_neg, 1'b0);
        check("reset disp_ovf", bus.disp_ovf, 1'b0);
        check("reset op_pend",  bus.op_pend,  2'd0);
        check("reset busy",     bus.busy,     1'b0);
        reset = 1'b0;

        // 12 + 34
        tbl.push_back(mk(K_D, 4'd1, 16'h0001, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_D, 4'd2, 16'h0012, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_O, 4'd1, 16'h0012, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_D, 4'd3, 16'h0003, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_D, 4'd4, 16'h0034, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_E, 4'd0, 16'h0046, 0, 0, 2'd1, 4));
        // 5 - 12 = -7, then chain + 3 -> 10
        tbl.push_back(mk(K_D, 4'd5, 16'h0005, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_O, 4'd2, 16'h0005, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_D, 4'd1, 16'h0001, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_D, 4'd2, 16'h0012, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_E, 4'd0, 16'h0007, 1, 0, 2'd2, 4));
        tbl.push_back(mk(K_O, 4'd1, 16'h0007, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_D, 4'd3, 16'h0003, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_E, 4'd0, 16'h0010, 0, 0, 2'd1, 4));
        // 9999 + 1 overflows
        tbl.push_back(mk(K_D, 4'd9, 16'h0009, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_D, 4'd9, 16'h0099, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_D, 4'd9, 16'h0999, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_D, 4'd9, 16'h9999, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_O, 4'd1, 16'h9999, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_D, 4'd1, 16'h0001, 0, 0, 2'd1, 0));
        tbl.push_back(mk(K_E, 4'd0, 16'h0000, 0, 1, 2'd1, 4));
        tbl.push_back(mk(K_D, 4'd7, 16'h0007, 0, 0, 2'd0, 0));
        // '=' in S_A ignored, op 3 ignored, op in S_B ignored; 7 - 8 = -1
        tbl.push_back(mk(K_E, 4'd0, 16'h0007, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_O, 4'd2, 16'h0007, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_O, 4'd3, 16'h0007, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_D, 4'd8, 16'h0008, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_O, 4'd1, 16'h0008, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_E, 4'd0, 16'h0001, 1, 0, 2'd2, 4));
        // set up 8 - 3 for the busy-press sequence
        tbl.push_back(mk(K_D, 4'd8, 16'h0008, 0, 0, 2'd0, 0));
        tbl.push_back(mk(K_O, 4'd2, 16'h0008, 0, 0, 2'd2, 0));
        tbl.push_back(mk(K_D, 4'd3, 16'h0003, 0, 0, 2'd2, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // '=' then digit 9 pressed while busy: must have no effect
        press(K_E, 4'd0, 1);
        check("busy_after_eq", bus.busy, 1'b1);
        @(posedge clk); #1;
        drive_key(K_D, 4'd9);
        repeat (3) @(posedge clk);
        #1;
        release_key();
        begin
            int n;
            n = 0;
            while (bus.busy && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("busy_press timeout", (n < 20), 1'b1);
        end
        repeat (5) @(posedge clk);
        #1;
        $display("busy_press disp=%04h neg=%0b op=%0d", bus.disp_bcd, bus.disp_neg, bus.op_pend);
        check("busy_press disp_bcd", bus.disp_bcd, 16'h0005);
        check("busy_press disp_neg", bus.disp_neg, 1'b0);
        check("busy_press op_pend",  bus.op_pend,  2'd2);

        // Digit overflow, out-of-range digit and a long press
        do_reset();
        apply(mk(K_D, 4'd10, 16'h0000, 0, 0, 2'd0, 0), "bad_digit");
        apply(mk(K_D, 4'd1,  16'h0001, 0, 0, 2'd0, 0), "long1");
        apply(mk(K_D, 4'd2,  16'h0012, 0, 0, 2'd0, 0), "long2");
        apply(mk(K_D, 4'd3,  16'h0123, 0, 0, 2'd0, 0), "long3");
        press(K_D, 4'd4, 50);
        @(posedge clk); #1;
        $display("long_hold disp=%04h", bus.disp_bcd);
        check("long_hold disp_bcd", bus.disp_bcd, 16'h1234);
        apply(mk(K_D, 4'd5, 16'h1234, 0, 0, 2'd0, 0), "fifth_digit");

        // Reset in the middle of a calculation
        do_reset();
        apply(mk(K_D, 4'd6, 16'h0006, 0, 0, 2'd0, 0), "rst6");
        apply(mk(K_O, 4'd1, 16'h0006, 0, 0, 2'd1, 0), "rst_op");
        apply(mk(K_D, 4'd7, 16'h0007, 0, 0, 2'd1, 0), "rst7");
        press(K_E, 4'd0, 1);
        @(posedge clk); #1;
        check("midcalc busy", bus.busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("midcalc_reset disp=%04h busy=%0b", bus.disp_bcd, bus.busy);
        check("midcalc disp_bcd", bus.disp_bcd, 16'h0000);
        check("midcalc disp_neg", bus.disp_neg, 1'b0);
        check("midcalc disp_ovf", bus.disp_ovf, 1'b0);
        check("midcalc op_pend",  bus.op_pend,  2'd0);
        check("midcalc busy",     bus.busy,     1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("midcalc settled disp_bcd", bus.disp_bcd, 16'h0000);

        // Key held across a reset edge yields no event
        drive_key(K_D, 4'd3);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        release_key();
        @(posedge clk); #1;
        $display("held_reset disp=%04h", bus.disp_bcd);
        check("held_reset disp_bcd", bus.disp_bcd, 16'h0000);

        apply(mk(K_D, 4'd2, 16'h0002, 0, 0, 2'd0, 0), "post2a");
        apply(mk(K_O, 4'd1, 16'h0002, 0, 0, 2'd1, 0), "post_op");
        apply(mk(K_D, 4'd2, 16'h0002, 0, 0, 2'd1, 0), "post2b");
        apply(mk(K_E, 4'd0, 16'h0004, 0, 0, 2'd1, 4), "post_eq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
